// File: rtl/aq_mmu_sysmap_ctrl_pkg.sv
//============================================================================
// aq_mmu_sysmap_ctrl_pkg: shared MMU sysmap types, requester indices, widths
// Rev 1.0
//============================================================================
`default_nettype none

package aq_mmu_sysmap_ctrl_pkg;

  localparam int FLG_W_DEF = 5;

  localparam logic [1:0] PTW = 2'd0;
  localparam logic [1:0] LSU = 2'd1;
  localparam logic [1:0] IFU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } sysmap_st_e;

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = PTW;
    if (oh[1]) idx = LSU;
    else if (oh[2]) idx = IFU;
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aq_mmu_sysmap_ctrl_rr.sv
//============================================================================
// aq_mmu_sysmap_rr: 3-way round-robin selector, priority starts after last grant
// Rev 1.0
//============================================================================
`default_nettype none

module aq_mmu_sysmap_rr
  import aq_mmu_sysmap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_req,
  input  logic       i_adv,
  output logic [2:0] o_gnt
);

  logic [1:0] r_last;
  logic [2:0] w_rot;
  logic [2:0] w_pick;

  // Rotate so bit 0 is the requester right after the last winner, pick lowest, rotate back
  always_comb begin
    w_rot  = i_req;
    w_pick = 3'b000;
    o_gnt  = 3'b000;
    case (r_last)
      PTW:     w_rot = {i_req[0], i_req[2], i_req[1]};
      LSU:     w_rot = {i_req[1], i_req[0], i_req[2]};
      default: w_rot = i_req;
    endcase
    if (w_rot[0])      w_pick = 3'b001;
    else if (w_rot[1]) w_pick = 3'b010;
    else if (w_rot[2]) w_pick = 3'b100;
    case (r_last)
      PTW:     o_gnt = {w_pick[1], w_pick[0], w_pick[2]};
      LSU:     o_gnt = {w_pick[0], w_pick[2], w_pick[1]};
      default: o_gnt = w_pick;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IFU;
    end else if (i_adv && (o_gnt != 3'b000)) begin
      r_last <= onehot_idx(o_gnt);
    end
  end

endmodule

`default_nettype wire

// File: rtl/aq_mmu_sysmap_ctrl.sv
//============================================================================
// aq_mmu_sysmap_ctrl: arbitrated sysmap lookup front-end with one-entry result cache
// Rev 1.0
//============================================================================
`default_nettype none

module aq_mmu_sysmap_ctrl
  import aq_mmu_sysmap_ctrl_pkg::*;
#(
  parameter int PA_W  = 28,
  parameter int FLG_W = FLG_W_DEF
) (
  input  logic             cpuclk,
  input  logic             cpurst,
  input  logic             ptw_sysmap_vld,
  input  logic             lsu_sysmap_vld,
  input  logic             ifu_sysmap_vld,
  input  logic [PA_W-1:0]  ptw_sysmap_pa,
  input  logic [PA_W-1:0]  lsu_sysmap_pa,
  input  logic [PA_W-1:0]  ifu_sysmap_pa,
  output logic [2:0]       ctrl_req_gnt,
  output logic [PA_W-1:0]  ctrl_sysmap_pa,
  input  logic [FLG_W-1:0] sysmap_ctrl_flg,
  output logic             ctrl_rsp_vld,
  output logic [2:0]       ctrl_rsp_id,
  output logic [FLG_W-1:0] ctrl_rsp_flg,
  input  logic [2:0]       rsp_rdy,
  input  logic             mmu_flush,
  input  logic             sysmap_cfg_upd
);

  sysmap_st_e       r_state;
  sysmap_st_e       w_state_nxt;
  logic [2:0]       w_req;
  logic [2:0]       w_rr_gnt;
  logic [2:0]       r_gnt;
  logic [2:0]       r_id;
  logic [PA_W-1:0]  r_pa;
  logic [PA_W-1:0]  w_pa_sel;
  logic [PA_W-1:0]  r_cache_pa;
  logic [FLG_W-1:0] r_cache_flg;
  logic [FLG_W-1:0] r_rsp_flg;
  logic             r_cache_vld;
  logic             r_rsp_vld;
  logic             w_take;
  logic             w_hit;
  logic             w_rdy;
  logic             w_fill;

  assign w_req = {ifu_sysmap_vld, lsu_sysmap_vld, ptw_sysmap_vld};

  aq_mmu_sysmap_rr u_rr (
    .clk   (cpuclk),
    .rst   (cpurst),
    .i_req (w_req),
    .i_adv (w_take),
    .o_gnt (w_rr_gnt)
  );

  // The grant-pulse cycle stays in IDLE and resolves hit/miss against the latched pa
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_fill      = 1'b0;
    w_hit       = r_cache_vld && (r_cache_pa == r_pa);
    w_rdy       = |(rsp_rdy & r_id);
    case (w_rr_gnt)
      3'b010:  w_pa_sel = lsu_sysmap_pa;
      3'b100:  w_pa_sel = ifu_sysmap_pa;
      default: w_pa_sel = ptw_sysmap_pa;
    endcase
    case (r_state)
      ST_IDLE: begin
        if (r_gnt != 3'b000) w_state_nxt = w_hit ? ST_RESP : ST_LOOKUP;
        else                 w_take      = |w_req;
      end
      ST_LOOKUP: begin
        w_state_nxt = ST_RESP;
        w_fill      = !sysmap_cfg_upd;
      end
      ST_RESP: begin
        if (w_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (mmu_flush) begin
      w_state_nxt = ST_IDLE;
      w_take      = 1'b0;
      w_fill      = 1'b0;
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_gnt       <= 3'b000;
      r_id        <= 3'b000;
      r_pa        <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_flg   <= '0;
      r_cache_vld <= 1'b0;
      r_cache_pa  <= '0;
      r_cache_flg <= '0;
    end else begin
      r_gnt     <= w_take ? w_rr_gnt : 3'b000;
      r_rsp_vld <= (w_state_nxt == ST_RESP);
      if (w_take) begin
        r_pa <= w_pa_sel;
        r_id <= w_rr_gnt;
      end
      if (r_state == ST_LOOKUP) begin
        r_rsp_flg <= sysmap_ctrl_flg;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_RESP)) begin
        r_rsp_flg <= r_cache_flg;
      end
      // A config update always beats a same-cycle fill
      if (sysmap_cfg_upd) r_cache_vld <= 1'b0;
      else if (w_fill)    r_cache_vld <= 1'b1;
      if (w_fill) begin
        r_cache_pa  <= r_pa;
        r_cache_flg <= sysmap_ctrl_flg;
      end
    end
  end

  assign ctrl_req_gnt   = r_gnt;
  assign ctrl_sysmap_pa = r_pa;
  assign ctrl_rsp_vld   = r_rsp_vld;
  assign ctrl_rsp_id    = r_id;
  assign ctrl_rsp_flg   = r_rsp_flg;

endmodule

`default_nettype wire

// File: tb/tb_aq_mmu_sysmap_ctrl.sv
//============================================================================
// tb_aq_mmu_sysmap_ctrl: transaction-timestamp model plus directed and random stimulus
// Rev 1.0
//============================================================================
`default_nettype none

module tb_aq_mmu_sysmap_ctrl;

  localparam int PA_W  = 28;
  localparam int FLG_W = 5;

  logic             cpuclk = 1'b0;
  logic             cpurst = 1'b1;
  logic [2:0]       vld = 3'b000;
  logic [PA_W-1:0]  pa [3];
  logic [2:0]       ctrl_req_gnt;
  logic [PA_W-1:0]  ctrl_sysmap_pa;
  logic [FLG_W-1:0] sysmap_ctrl_flg;
  logic             ctrl_rsp_vld;
  logic [2:0]       ctrl_rsp_id;
  logic [FLG_W-1:0] ctrl_rsp_flg;
  logic [2:0]       rsp_rdy = 3'b000;
  logic             mmu_flush = 1'b0;
  logic             sysmap_cfg_upd = 1'b0;
  int               epoch = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 cpuclk = ~cpuclk;

  // Stand-in sysmap: contents depend on the address and the configuration epoch
  function automatic logic [FLG_W-1:0] sysflg(input logic [PA_W-1:0] a, input int ep);
    logic [31:0] s;
    s = 32'(a) * 32'd7 + (32'(a) >> 12) + 32'(ep) * 32'd3;
    return s[FLG_W-1:0] ^ 5'h0A;
  endfunction

  assign sysmap_ctrl_flg = sysflg(ctrl_sysmap_pa, epoch);

  aq_mmu_sysmap_ctrl #(.PA_W(PA_W), .FLG_W(FLG_W)) dut (
    .cpuclk          (cpuclk),
    .cpurst          (cpurst),
    .ptw_sysmap_vld  (vld[0]),
    .lsu_sysmap_vld  (vld[1]),
    .ifu_sysmap_vld  (vld[2]),
    .ptw_sysmap_pa   (pa[0]),
    .lsu_sysmap_pa   (pa[1]),
    .ifu_sysmap_pa   (pa[2]),
    .ctrl_req_gnt    (ctrl_req_gnt),
    .ctrl_sysmap_pa  (ctrl_sysmap_pa),
    .sysmap_ctrl_flg (sysmap_ctrl_flg),
    .ctrl_rsp_vld    (ctrl_rsp_vld),
    .ctrl_rsp_id     (ctrl_rsp_id),
    .ctrl_rsp_flg    (ctrl_rsp_flg),
    .rsp_rdy         (rsp_rdy),
    .mmu_flush       (mmu_flush),
    .sysmap_cfg_upd  (sysmap_cfg_upd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time, described by the cycle numbers of its grant and response
  int               cyc = 0;
  bit               t_act = 0, t_dec = 0, t_miss = 0;
  int               t_g = 0, t_r = 0, t_own = 0;
  logic [PA_W-1:0]  t_pa = '0;
  logic [FLG_W-1:0] t_flg = '0;
  bit               c_v = 0;
  logic [PA_W-1:0]  c_pa = '0;
  logic [FLG_W-1:0] c_flg = '0;
  int               last = 2;
  logic [PA_W-1:0]  e_lpa = '0;
  logic [2:0]       e_gnt = 3'b000;
  bit               e_vld = 0;
  logic [2:0]       e_id = 3'b000;
  logic [FLG_W-1:0] e_flg = '0;

  task automatic model_step();
    bit         fl, up;
    logic [2:0] rd;
    fl = mmu_flush;
    up = sysmap_cfg_upd;
    rd = rsp_rdy;
    if (cpurst) begin
      t_act = 0; c_v = 0; c_pa = '0; c_flg = '0; last = 2; e_lpa = '0;
    end else begin
      if (t_act) begin
        if (cyc == t_g) begin
          t_dec = 1;
          if (c_v && c_pa == t_pa) begin
            t_flg = c_flg; t_r = cyc + 1; t_miss = 0;
          end else begin
            t_r = cyc + 2; t_miss = 1;
          end
        end else if (t_miss && cyc == t_g + 1) begin
          t_flg = sysflg(t_pa, epoch);
          if (!fl && !up) begin
            c_v = 1; c_pa = t_pa; c_flg = t_flg;
          end
        end else if (t_dec && cyc >= t_r && rd[t_own[1:0]]) begin
          t_act = 0;
        end
        if (fl) t_act = 0;
      end else if (!fl && vld != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (last + k) % 3;
          if (!t_act && vld[idx[1:0]]) begin
            t_act = 1; t_own = idx; t_g = cyc + 1; t_dec = 0; t_miss = 0;
            t_pa = pa[idx[1:0]]; e_lpa = t_pa; last = idx;
          end
        end
      end
      if (up) c_v = 0;
    end
    cyc++;
    e_gnt = (t_act && t_g == cyc) ? 3'(1 << t_own) : 3'b000;
    e_vld = t_act && t_dec && (cyc >= t_r);
    e_id  = 3'(1 << t_own);
    e_flg = t_flg;
  endtask

  initial forever begin
    @(posedge cpuclk);
    model_step();
  end

  initial forever begin
    @(negedge cpuclk);
    chk("model_gnt", 32'(ctrl_req_gnt), 32'(e_gnt));
    chk("model_rsp_vld", 32'(ctrl_rsp_vld), 32'(e_vld));
    chk("model_sysmap_pa", 32'(ctrl_sysmap_pa), 32'(e_lpa));
    if (e_vld) begin
      chk("model_rsp_id", 32'(ctrl_rsp_id), 32'(e_id));
      chk("model_rsp_flg", 32'(ctrl_rsp_flg), 32'(e_flg));
    end
  end

  task automatic tick();
    @(posedge cpuclk);
    #2;
  endtask

  task automatic drain();
    vld = 3'b000; rsp_rdy = 3'b111; mmu_flush = 1'b0; sysmap_cfg_upd = 1'b0;
    repeat (6) tick();
  endtask

  logic [2:0] got[$];

  initial begin
    pa[0] = '0; pa[1] = '0; pa[2] = '0;
    tick(); tick();
    chk("rst_gnt", 32'(ctrl_req_gnt), 32'h0);
    chk("rst_rsp_vld", 32'(ctrl_rsp_vld), 32'h0);
    chk("rst_sysmap_pa", 32'(ctrl_sysmap_pa), 32'h0);
    chk("rst_rsp_id", 32'(ctrl_rsp_id), 32'h0);
    chk("rst_rsp_flg", 32'(ctrl_rsp_flg), 32'h0);

    // LSU miss right after reset
    cpurst = 1'b0;
    pa[1] = 28'h0001000; vld[1] = 1'b1;
    tick();
    chk("miss_gnt", 32'(ctrl_req_gnt), 32'h2);
    vld[1] = 1'b0;
    tick();
    chk("miss_lookup_pa", 32'(ctrl_sysmap_pa), 32'h0001000);
    chk("miss_no_early_vld", 32'(ctrl_rsp_vld), 32'h0);
    tick();
    chk("miss_rsp_vld", 32'(ctrl_rsp_vld), 32'h1);
    chk("miss_rsp_id", 32'(ctrl_rsp_id), 32'h2);
    chk("miss_rsp_flg", 32'(ctrl_rsp_flg), 32'h0B);
    rsp_rdy = 3'b010;
    tick();
    chk("miss_rsp_done", 32'(ctrl_rsp_vld), 32'h0);

    // IFU hit on the same page
    pa[2] = 28'h0001000; vld[2] = 1'b1; rsp_rdy = 3'b111;
    tick();
    chk("hit_gnt", 32'(ctrl_req_gnt), 32'h4);
    vld[2] = 1'b0;
    tick();
    chk("hit_rsp_vld", 32'(ctrl_rsp_vld), 32'h1);
    chk("hit_rsp_id", 32'(ctrl_rsp_id), 32'h4);
    chk("hit_rsp_flg", 32'(ctrl_rsp_flg), 32'h0B);
    tick();

    // Round-robin with everyone asking continuously
    pa[0] = 28'h0002000; pa[1] = 28'h0003000; pa[2] = 28'h0004000; vld = 3'b111;
    for (int i = 0; i < 40 && got.size() < 4; i++) begin
      tick();
      if (ctrl_req_gnt != 3'b000) got.push_back(ctrl_req_gnt);
    end
    while (got.size() < 4) got.push_back(3'b000);
    chk("rr_order0", 32'(got[0]), 32'h1);
    chk("rr_order1", 32'(got[1]), 32'h2);
    chk("rr_order2", 32'(got[2]), 32'h4);
    chk("rr_order3", 32'(got[3]), 32'h1);
    drain();

    // Response held under backpressure
    rsp_rdy = 3'b000; pa[0] = 28'h0005000; vld[0] = 1'b1;
    tick();
    chk("bp_gnt", 32'(ctrl_req_gnt), 32'h1);
    vld[0] = 1'b0; pa[1] = 28'h0003000; vld[1] = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      rsp_rdy = (i == 2) ? 3'b110 : 3'b000;
      chk("bp_hold_vld", 32'(ctrl_rsp_vld), 32'h1);
      chk("bp_hold_id", 32'(ctrl_rsp_id), 32'h1);
      chk("bp_hold_flg", 32'(ctrl_rsp_flg), 32'h0F);
      chk("bp_no_gnt", 32'(ctrl_req_gnt), 32'h0);
      tick();
    end
    rsp_rdy = 3'b001;
    tick();
    chk("bp_release", 32'(ctrl_rsp_vld), 32'h0);
    drain();

    // Flush during LOOKUP leaves the cache unfilled
    pa[2] = 28'h0006000; vld[2] = 1'b1;
    tick();
    chk("fl_gnt", 32'(ctrl_req_gnt), 32'h4);
    vld[2] = 1'b0;
    tick();
    mmu_flush = 1'b1;
    tick();
    chk("fl_no_rsp0", 32'(ctrl_rsp_vld), 32'h0);
    mmu_flush = 1'b0;
    tick();
    chk("fl_no_rsp1", 32'(ctrl_rsp_vld), 32'h0);
    vld[2] = 1'b1;
    tick();
    chk("fl_regnt", 32'(ctrl_req_gnt), 32'h4);
    vld[2] = 1'b0;
    tick();
    chk("fl_miss_t1", 32'(ctrl_rsp_vld), 32'h0);
    tick();
    chk("fl_miss_t2", 32'(ctrl_rsp_vld), 32'h1);
    chk("fl_miss_flg", 32'(ctrl_rsp_flg), 32'h0C);
    drain();

    // Config update coinciding with the fill
    pa[1] = 28'h0008000; vld[1] = 1'b1;
    tick();
    chk("cu_gnt", 32'(ctrl_req_gnt), 32'h2);
    vld[1] = 1'b0;
    tick();
    sysmap_cfg_upd = 1'b1; epoch++;
    tick();
    sysmap_cfg_upd = 1'b0;
    chk("cu_rsp_vld", 32'(ctrl_rsp_vld), 32'h1);
    chk("cu_rsp_flg", 32'(ctrl_rsp_flg), 32'h01);
    tick();
    vld[1] = 1'b1;
    tick();
    chk("cu_regnt", 32'(ctrl_req_gnt), 32'h2);
    vld[1] = 1'b0;
    tick();
    chk("cu_miss_t1", 32'(ctrl_rsp_vld), 32'h0);
    tick();
    chk("cu_miss_t2", 32'(ctrl_rsp_vld), 32'h1);
    drain();

    // Reset in the middle of a lookup
    pa[0] = 28'h0009000; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    chk("mrst_vld", 32'(ctrl_rsp_vld), 32'h0);
    tick();
    chk("mrst_vld2", 32'(ctrl_rsp_vld), 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i] && ctrl_req_gnt[i]) begin
          vld[i] = 1'b0;
        end else if (vld[i]) begin
          if ($urandom_range(0, 19) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       pa[i] = 28'h0001000;
            1:       pa[i] = 28'h0001001;
            2:       pa[i] = 28'h0002000;
            default: pa[i] = 28'hFFFFFFF;
          endcase
          vld[i] = 1'b1;
        end
      end
      rsp_rdy   = 3'($urandom_range(0, 7));
      mmu_flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 29) == 0) begin
        sysmap_cfg_upd = 1'b1; epoch++;
      end else begin
        sysmap_cfg_upd = 1'b0;
      end
      cpurst = ($urandom_range(0, 299) == 0);
      tick();
    end
    cpurst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
